darkriscv_bus_monitor: RTL and testbench



---
 rtl/darkriscv_mon_pkg.sv | 47 ++++
 rtl/darkriscv_instr_classify.sv | 65 ++++++
 rtl/darkriscv_bus_monitor.sv | 144 ++++++++++++++
 tb/tb_darkriscv_bus_monitor.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/darkriscv_mon_pkg.sv
// Shared definitions for the darkriscv bus monitor: opcodes, instruction classes,
// error codes, monitor states and a small saturating helper.
package darkriscv_mon_pkg;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BCC   = 7'b1100011;
    localparam logic [6:0] OP_LCC   = 7'b0000011;
    localparam logic [6:0] OP_SCC   = 7'b0100011;
    localparam logic [6:0] OP_MCC   = 7'b0010011;
    localparam logic [6:0] OP_RCC   = 7'b0110011;

    localparam logic [6:0] F7_ZERO = 7'd0;
    localparam logic [6:0] F7_ALT  = 7'd32;

    typedef enum logic [2:0] {
        CLS_ALU_R   = 3'd0,
        CLS_ALU_I   = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JUMP    = 3'd5,
        CLS_UPPER   = 3'd6,
        CLS_ILLEGAL = 3'd7
    } instr_class_e;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_ILLEGAL = 3'd1,
        ERR_RDWR    = 3'd2,
        ERR_WR_MISS = 3'd3,
        ERR_WR_SPUR = 3'd4
    } err_code_e;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2
    } mon_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/darkriscv_instr_classify.sv
// Pure combinational decode of a 32-bit RV32I instruction word into one of eight
// monitor classes; malformed funct3/funct7 combinations fall into CLS_ILLEGAL.
module darkriscv_instr_classify
    import darkriscv_mon_pkg::*;
(
    input  logic [31:0]  idata,
    output instr_class_e cls
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    logic       unused_bits_s;

    assign opcode_s      = idata[6:0];
    assign funct3_s      = idata[14:12];
    assign funct7_s      = idata[31:25];
    assign unused_bits_s = ^{idata[24:15], idata[11:7]};

    // Opcode-driven class selection with per-opcode funct legality
    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode_s)
            OP_RCC: begin
                // funct7=32 only exists for SUB and SRA
                if (funct7_s == F7_ZERO ||
                    (funct7_s == F7_ALT && (funct3_s == 3'd0 || funct3_s == 3'd5)))
                    cls = CLS_ALU_R;
                else
                    cls = CLS_ILLEGAL;
            end
            OP_MCC: begin
                if (funct3_s == 3'd1) begin
                    if (funct7_s == F7_ZERO) cls = CLS_ALU_I;
                    else                     cls = CLS_ILLEGAL;
                end else if (funct3_s == 3'd5) begin
                    if (funct7_s == F7_ZERO || funct7_s == F7_ALT) cls = CLS_ALU_I;
                    else                                            cls = CLS_ILLEGAL;
                end else begin
                    cls = CLS_ALU_I;
                end
            end
            OP_LCC: begin
                if (funct3_s == 3'd3 || funct3_s == 3'd6 || funct3_s == 3'd7) cls = CLS_ILLEGAL;
                else                                                          cls = CLS_LOAD;
            end
            OP_SCC: begin
                if (funct3_s <= 3'd2) cls = CLS_STORE;
                else                  cls = CLS_ILLEGAL;
            end
            OP_BCC: begin
                if (funct3_s == 3'd2 || funct3_s == 3'd3) cls = CLS_ILLEGAL;
                else                                      cls = CLS_BRANCH;
            end
            OP_JAL:  cls = CLS_JUMP;
            OP_JALR: begin
                if (funct3_s == 3'd0) cls = CLS_JUMP;
                else                  cls = CLS_ILLEGAL;
            end
            OP_LUI, OP_AUIPC: cls = CLS_UPPER;
            default: cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/darkriscv_bus_monitor.sv
// Passive runtime monitor beside the darkriscv core: class counters, store/WR
// latency tracking, and a sticky first-error record with an ARM/RUN/FAIL state.
module darkriscv_bus_monitor
    import darkriscv_mon_pkg::*;
#(
    parameter int STAGES      = 2,
    parameter int CNT_W       = 16,
    parameter int WARMUP      = 4,
    parameter int STOP_ON_ERR = 1
) (
    input  logic               CLK,
    input  logic               RES,
    input  logic               HLT,
    input  logic [31:0]        IDATA,
    input  logic               RD,
    input  logic               WR,
    input  logic               IDLE,
    input  logic               CLR,
    output logic [8*CNT_W-1:0] CNT,
    output logic [CNT_W-1:0]   IDLE_CNT,
    output logic               ERR,
    output logic [2:0]         ERR_CODE,
    output logic [7:0]         ERR_CNT,
    output logic [1:0]         STATE
);

    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [3:0]       WARM_INIT = 4'(WARMUP);

    mon_state_e        state_r;
    logic [3:0]        warm_r;
    logic [STAGES-1:0] track_r;
    logic [CNT_W-1:0]  cnt_r [8];
    logic [CNT_W-1:0]  idle_cnt_r;
    logic              err_r;
    err_code_e         err_code_r;
    logic [7:0]        err_cnt_r;

    instr_class_e      cls_s;
    logic              run_s;
    logic              step_s;
    logic              due_s;
    logic              any_err_s;
    err_code_e         first_err_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    darkriscv_instr_classify u_classify (
        .idata (IDATA),
        .cls   (cls_s)
    );

    // Error detection; the if-chain order gives the lowest code priority
    always_comb begin
        run_s       = (state_r == ST_RUN) && !CLR;
        step_s      = run_s && !HLT;
        due_s       = track_r[STAGES-1];
        first_err_s = ERR_NONE;
        if (step_s && cls_s == CLS_ILLEGAL)
            first_err_s = ERR_ILLEGAL;
        else if (run_s && RD && WR)
            first_err_s = ERR_RDWR;
        else if (step_s && due_s && !WR)
            first_err_s = ERR_WR_MISS;
        else if (step_s && WR && !due_s)
            first_err_s = ERR_WR_SPUR;
        else
            first_err_s = ERR_NONE;
        any_err_s = (first_err_s != ERR_NONE);
    end

    // Monitor FSM with warmup countdown and sticky error capture
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_r    <= ST_ARM;
            warm_r     <= WARM_INIT;
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
            err_cnt_r  <= 8'd0;
        end else if (CLR) begin
            state_r    <= ST_ARM;
            warm_r     <= WARM_INIT;
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
            err_cnt_r  <= 8'd0;
        end else begin
            case (state_r)
                ST_ARM: begin
                    if (warm_r <= 4'd1) begin
                        warm_r  <= 4'd0;
                        state_r <= ST_RUN;
                    end else begin
                        warm_r <= warm_r - 4'd1;
                    end
                end
                ST_RUN: begin
                    if (any_err_s) begin
                        err_cnt_r <= sat_inc8(err_cnt_r);
                        if (!err_r) begin
                            err_r      <= 1'b1;
                            err_code_r <= first_err_s;
                        end
                        if (STOP_ON_ERR != 0) state_r <= ST_FAIL;
                    end
                end
                ST_FAIL: state_r <= ST_FAIL;
                default: state_r <= ST_ARM;
            endcase
        end
    end

    // Class/idle counters and the store-to-WR shift tracker advance on unstalled RUN cycles
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            for (int k = 0; k < 8; k++) cnt_r[k] <= {CNT_W{1'b0}};
            idle_cnt_r <= {CNT_W{1'b0}};
            track_r    <= {STAGES{1'b0}};
        end else if (CLR) begin
            for (int k = 0; k < 8; k++) cnt_r[k] <= {CNT_W{1'b0}};
            idle_cnt_r <= {CNT_W{1'b0}};
            track_r    <= {STAGES{1'b0}};
        end else if (step_s) begin
            cnt_r[cls_s] <= sat_inc(cnt_r[cls_s]);
            if (IDLE) idle_cnt_r <= sat_inc(idle_cnt_r);
            track_r <= {track_r[STAGES-2:0], (cls_s == CLS_STORE)};
        end
    end

    // Pack the counter bank onto the flat output bus
    always_comb begin
        CNT = {(8*CNT_W){1'b0}};
        for (int k = 0; k < 8; k++) CNT[k*CNT_W +: CNT_W] = cnt_r[k];
    end

    assign IDLE_CNT = idle_cnt_r;
    assign ERR      = err_r;
    assign ERR_CODE = err_code_r;
    assign ERR_CNT  = err_cnt_r;
    assign STATE    = state_r;

endmodule

// File: tb/tb_darkriscv_bus_monitor.sv
// Self-checking bench: two monitor configurations share one stimulus stream and
// are compared against a cycle-level reference model of the monitor rules.
module tb_darkriscv_bus_monitor;

    localparam logic [31:0] I_ADDI = 32'h00100093;
    localparam logic [31:0] I_SW   = 32'h00112023;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_NOP  = 32'h00000013;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

    localparam int P_STAGES [2] = '{2, 3};
    localparam int P_MAX    [2] = '{65535, 15};
    localparam int P_WARM   [2] = '{4, 3};
    localparam int P_STOP   [2] = '{1, 0};

    logic        CLK = 1'b0;
    logic        RES, HLT, RD, WR, IDLE, CLR;
    logic [31:0] IDATA;

    logic [127:0] cnt_a;
    logic [15:0]  idle_a;
    logic         err_a;
    logic [2:0]   code_a;
    logic [7:0]   ecnt_a;
    logic [1:0]   state_a;
    logic [31:0]  cnt_b;
    logic [3:0]   idle_b;
    logic         err_b;
    logic [2:0]   code_b;
    logic [7:0]   ecnt_b;
    logic [1:0]   state_b;

    int total = 0;
    int bad   = 0;

    int m_cnt   [2][8];
    int m_idle  [2];
    int m_err   [2];
    int m_code  [2];
    int m_ecnt  [2];
    int m_state [2];
    int m_warm  [2];
    int ustep   [2];
    bit ring    [2][64];

    always #5 CLK = ~CLK;

    darkriscv_bus_monitor #(.STAGES(2), .CNT_W(16), .WARMUP(4), .STOP_ON_ERR(1)) u_dut_a (
        .CLK(CLK), .RES(RES), .HLT(HLT), .IDATA(IDATA), .RD(RD), .WR(WR), .IDLE(IDLE), .CLR(CLR),
        .CNT(cnt_a), .IDLE_CNT(idle_a), .ERR(err_a), .ERR_CODE(code_a), .ERR_CNT(ecnt_a), .STATE(state_a)
    );

    darkriscv_bus_monitor #(.STAGES(3), .CNT_W(4), .WARMUP(3), .STOP_ON_ERR(0)) u_dut_b (
        .CLK(CLK), .RES(RES), .HLT(HLT), .IDATA(IDATA), .RD(RD), .WR(WR), .IDLE(IDLE), .CLR(CLR),
        .CNT(cnt_b), .IDLE_CNT(idle_b), .ERR(err_b), .ERR_CODE(code_b), .ERR_CNT(ecnt_b), .STATE(state_b)
    );

    function automatic int obs_cnt(input int i, input int k);
        if (i == 0) return int'(cnt_a[k*16 +: 16]);
        else        return int'(cnt_b[k*4 +: 4]);
    endfunction
    function automatic int obs_idle(input int i);
        return (i == 0) ? int'(idle_a) : int'(idle_b);
    endfunction
    function automatic int obs_err(input int i);
        return (i == 0) ? int'(err_a) : int'(err_b);
    endfunction
    function automatic int obs_code(input int i);
        return (i == 0) ? int'(code_a) : int'(code_b);
    endfunction
    function automatic int obs_ecnt(input int i);
        return (i == 0) ? int'(ecnt_a) : int'(ecnt_b);
    endfunction
    function automatic int obs_state(input int i);
        return (i == 0) ? int'(state_a) : int'(state_b);
    endfunction

    // Reference classification from the RV32I encoding rules
    function automatic int ref_class(input logic [31:0] ins);
        int f3;
        int f7;
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        case (ins[6:0])
            7'b0110011: return (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5))) ? 0 : 7;
            7'b0010011: begin
                if (f3 == 1) return (f7 == 0) ? 1 : 7;
                if (f3 == 5) return (f7 == 0 || f7 == 32) ? 1 : 7;
                return 1;
            end
            7'b0000011: return (f3 == 3 || f3 == 6 || f3 == 7) ? 7 : 2;
            7'b0100011: return (f3 < 3) ? 3 : 7;
            7'b1100011: return (f3 == 2 || f3 == 3) ? 7 : 4;
            7'b1101111: return 5;
            7'b1100111: return (f3 == 0) ? 5 : 7;
            7'b0110111, 7'b0010111: return 6;
            default: return 7;
        endcase
    endfunction

    task automatic model_reset(input int i);
        for (int k = 0; k < 8; k++) m_cnt[i][k] = 0;
        for (int j = 0; j < 64; j++) ring[i][j] = 1'b0;
        m_idle[i] = 0; m_err[i] = 0; m_code[i] = 0; m_ecnt[i] = 0;
        m_state[i] = 0; m_warm[i] = P_WARM[i]; ustep[i] = 0;
    endtask

    // One clock of the monitor rules; WR due is scheduled by unstalled-cycle index
    task automatic model_step(input int i);
        int c;
        int code;
        bit due;
        if (CLR) begin
            model_reset(i);
            return;
        end
        if (m_state[i] == 0) begin
            if (m_warm[i] <= 1) begin m_warm[i] = 0; m_state[i] = 1; end
            else m_warm[i] = m_warm[i] - 1;
        end else if (m_state[i] == 1) begin
            c   = ref_class(IDATA);
            due = 1'b0;
            if (!HLT) begin
                due = ring[i][ustep[i] % 64];
                ring[i][ustep[i] % 64] = 1'b0;
                if (c == 3) ring[i][(ustep[i] + P_STAGES[i]) % 64] = 1'b1;
                ustep[i] = ustep[i] + 1;
                if (m_cnt[i][c] < P_MAX[i]) m_cnt[i][c] = m_cnt[i][c] + 1;
                if (IDLE && m_idle[i] < P_MAX[i]) m_idle[i] = m_idle[i] + 1;
            end
            if (!HLT && c == 7)          code = 1;
            else if (RD && WR)           code = 2;
            else if (!HLT && due && !WR) code = 3;
            else if (!HLT && WR && !due) code = 4;
            else                         code = 0;
            if (code != 0) begin
                if (m_ecnt[i] < 255) m_ecnt[i] = m_ecnt[i] + 1;
                if (m_err[i] == 0) begin m_err[i] = 1; m_code[i] = code; end
                if (P_STOP[i] != 0) m_state[i] = 2;
            end
        end
    endtask

    task automatic cycle();
        model_step(0);
        model_step(1);
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic hlt, input logic [31:0] ins, input logic rd, input logic wr);
        HLT = hlt; IDATA = ins; RD = rd; WR = wr;
    endtask

    task automatic run_warmup();
        set_in(1'b1, I_NOP, 1'b0, 1'b0);
        IDLE = 1'b0;
        CLR = 1'b1;
        cycle();
        CLR = 1'b0;
        repeat (5) cycle();
    endtask

    task automatic test_reset();
        #2 RES = 1'b0;
        #3;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs_state(i) !== 0 || obs_err(i) !== 0 || obs_code(i) !== 0 || obs_ecnt(i) !== 0 || obs_idle(i) !== 0) begin
                bad++;
                $display("FAIL reset[%0d] state=%0d err=%0d code=%0d ecnt=%0d idle=%0d, all want 0",
                         i, obs_state(i), obs_err(i), obs_code(i), obs_ecnt(i), obs_idle(i));
            end
            for (int k = 0; k < 8; k++) begin
                total++;
                if (obs_cnt(i, k) !== 0) begin
                    bad++;
                    $display("FAIL reset_cnt[%0d][%0d] got %0d want 0", i, k, obs_cnt(i, k));
                end
            end
        end
        @(posedge CLK);
        #1;
        RES = 1'b1;
    endtask

    task automatic test_warmup();
        for (int c = 1; c <= 6; c++) begin
            set_in((c == 2 || c == 6) ? 1'b0 : 1'b1, I_ADDI, 1'b0, 1'b0);
            cycle();
            if (c == 2 || c == 6) begin
                for (int i = 0; i < 2; i++) begin
                    total++;
                    if (obs_cnt(i, 1) !== m_cnt[i][1] || obs_state(i) !== m_state[i]) begin
                        bad++;
                        $display("FAIL warmup[%0d] c%0d cnt1=%0d state=%0d want %0d/%0d",
                                 i, c, obs_cnt(i, 1), obs_state(i), m_cnt[i][1], m_state[i]);
                    end
                end
            end
        end
        total++;
        if (obs_cnt(0, 1) !== 1 || obs_state(0) !== 1) begin
            bad++;
            $display("FAIL warmup_run cnt1=%0d state=%0d want 1/1", obs_cnt(0, 1), obs_state(0));
        end
    endtask

    task automatic test_store_ok();
        set_in(1'b0, I_SW,  1'b0, 1'b0); cycle();
        set_in(1'b0, I_NOP, 1'b0, 1'b0); cycle();
        set_in(1'b0, I_NOP, 1'b0, 1'b1); cycle();
        set_in(1'b0, I_SW,  1'b0, 1'b0); cycle();
        set_in(1'b0, I_NOP, 1'b0, 1'b0); cycle();
        set_in(1'b1, I_NOP, 1'b0, 1'b0); repeat (3) cycle();
        set_in(1'b0, I_NOP, 1'b0, 1'b1); cycle();
        set_in(1'b1, I_NOP, 1'b0, 1'b0); cycle();
        total++;
        if (obs_err(0) !== 0 || obs_cnt(0, 3) !== 2) begin
            bad++;
            $display("FAIL store_ok err=%0d cnt3=%0d want 0/2", obs_err(0), obs_cnt(0, 3));
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs_err(i) !== m_err[i] || obs_code(i) !== m_code[i] || obs_ecnt(i) !== m_ecnt[i] || obs_state(i) !== m_state[i]) begin
                bad++;
                $display("FAIL store_err[%0d] err/code/ecnt/state=%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i,
                         obs_err(i), obs_code(i), obs_ecnt(i), obs_state(i), m_err[i], m_code[i], m_ecnt[i], m_state[i]);
            end
        end
    endtask

    task automatic test_clr_mid_store();
        run_warmup();
        set_in(1'b0, I_SW, 1'b0, 1'b0); cycle();
        set_in(1'b0, I_NOP, 1'b0, 1'b0);
        CLR = 1'b1; cycle(); CLR = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs_cnt(i, 3) !== 0 || obs_state(i) !== 0 || obs_err(i) !== 0) begin
                bad++;
                $display("FAIL clr[%0d] cnt3=%0d state=%0d err=%0d want 0/0/0", i, obs_cnt(i, 3), obs_state(i), obs_err(i));
            end
        end
        repeat (8) cycle();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs_err(i) !== 0 || obs_state(i) !== 1 || obs_cnt(i, 1) !== m_cnt[i][1]) begin
                bad++;
                $display("FAIL clr_after[%0d] err=%0d state=%0d cnt1=%0d want 0/1/%0d",
                         i, obs_err(i), obs_state(i), obs_cnt(i, 1), m_cnt[i][1]);
            end
        end
    endtask

    task automatic test_wr_miss();
        run_warmup();
        set_in(1'b0, I_SW, 1'b0, 1'b0); cycle();
        set_in(1'b0, I_NOP, 1'b0, 1'b0); repeat (3) cycle();
        total++;
        if (obs_err(0) !== 1 || obs_code(0) !== 3 || obs_state(0) !== 2) begin
            bad++;
            $display("FAIL wr_miss err=%0d code=%0d state=%0d want 1/3/2", obs_err(0), obs_code(0), obs_state(0));
        end
        set_in(1'b0, I_ADDI, 1'b0, 1'b0); repeat (3) cycle();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs_cnt(i, 1) !== m_cnt[i][1] || obs_cnt(i, 3) !== m_cnt[i][3] || obs_code(i) !== m_code[i] || obs_ecnt(i) !== m_ecnt[i]) begin
                bad++;
                $display("FAIL frozen[%0d] cnt1=%0d cnt3=%0d code=%0d ecnt=%0d want %0d/%0d/%0d/%0d", i,
                         obs_cnt(i, 1), obs_cnt(i, 3), obs_code(i), obs_ecnt(i), m_cnt[i][1], m_cnt[i][3], m_code[i], m_ecnt[i]);
            end
        end
    endtask

    task automatic test_illegal_rdwr();
        run_warmup();
        set_in(1'b0, I_BAD, 1'b1, 1'b1); cycle();
        set_in(1'b1, I_NOP, 1'b0, 1'b0); cycle();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs_code(i) !== 1 || obs_ecnt(i) !== 1 || obs_err(i) !== 1 || obs_state(i) !== m_state[i] || obs_cnt(i, 7) !== m_cnt[i][7]) begin
                bad++;
                $display("FAIL illegal_rdwr[%0d] code=%0d ecnt=%0d err=%0d state=%0d cnt7=%0d want 1/1/1/%0d/%0d",
                         i, obs_code(i), obs_ecnt(i), obs_err(i), obs_state(i), obs_cnt(i, 7), m_state[i], m_cnt[i][7]);
            end
        end
    endtask

    task automatic test_saturate();
        run_warmup();
        IDLE = 1'b1;
        set_in(1'b0, I_ADD, 1'b0, 1'b0); repeat (20) cycle();
        IDLE = 1'b0;
        total++;
        if (obs_cnt(1, 0) !== 15 || obs_idle(1) !== 15 || obs_cnt(0, 0) !== 20 || obs_idle(0) !== 20) begin
            bad++;
            $display("FAIL saturate b_cnt0=%0d b_idle=%0d a_cnt0=%0d a_idle=%0d want 15/15/20/20",
                     obs_cnt(1, 0), obs_idle(1), obs_cnt(0, 0), obs_idle(0));
        end
        set_in(1'b0, I_NOP, 1'b0, 1'b1); cycle();
        set_in(1'b1, I_NOP, 1'b0, 1'b0); cycle();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs_code(i) !== 4 || obs_state(i) !== m_state[i] || obs_ecnt(i) !== m_ecnt[i]) begin
                bad++;
                $display("FAIL wr_spur[%0d] code=%0d state=%0d ecnt=%0d want 4/%0d/%0d",
                         i, obs_code(i), obs_state(i), obs_ecnt(i), m_state[i], m_ecnt[i]);
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 10))
            0: ins[6:0] = 7'b0110111;
            1: ins[6:0] = 7'b0010111;
            2: ins[6:0] = 7'b1101111;
            3: ins[6:0] = 7'b1100111;
            4: ins[6:0] = 7'b1100011;
            5: ins[6:0] = 7'b0000011;
            6: ins[6:0] = 7'b0100011;
            7: ins[6:0] = 7'b0010011;
            8: ins[6:0] = 7'b0110011;
            default: ins[6:0] = ins[6:0];
        endcase
        case ($urandom_range(0, 3))
            0: ins[31:25] = 7'd0;
            1: ins[31:25] = 7'd32;
            default: ins[31:25] = ins[31:25];
        endcase
        return ins;
    endfunction

    task automatic test_random();
        bit due_a;
        run_warmup();
        for (int n = 0; n < 400; n++) begin
            HLT   = ($urandom_range(0, 3) == 0);
            IDATA = rand_instr();
            IDLE  = ($urandom_range(0, 2) == 0);
            RD    = ($urandom_range(0, 29) == 0);
            CLR   = ($urandom_range(0, 59) == 0);
            due_a = (m_state[0] == 1) && ring[0][ustep[0] % 64];
            if (due_a && !HLT) WR = ($urandom_range(0, 19) != 0);
            else               WR = ($urandom_range(0, 49) == 0);
            cycle();
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 8; k++) begin
                    total++;
                    if (obs_cnt(i, k) !== m_cnt[i][k]) begin
                        bad++;
                        $display("FAIL rnd_cnt[%0d][%0d] n=%0d got %0d want %0d", i, k, n, obs_cnt(i, k), m_cnt[i][k]);
                    end
                end
                total++;
                if (obs_idle(i) !== m_idle[i] || obs_err(i) !== m_err[i] || obs_code(i) !== m_code[i] ||
                    obs_ecnt(i) !== m_ecnt[i] || obs_state(i) !== m_state[i]) begin
                    bad++;
                    $display("FAIL rnd_status[%0d] n=%0d idle/err/code/ecnt/state=%0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d",
                             i, n, obs_idle(i), obs_err(i), obs_code(i), obs_ecnt(i), obs_state(i),
                             m_idle[i], m_err[i], m_code[i], m_ecnt[i], m_state[i]);
                end
            end
        end
        CLR = 1'b0;
    endtask

    task automatic test_async_reset();
        run_warmup();
        set_in(1'b0, I_ADDI, 1'b0, 1'b0); repeat (2) cycle();
        set_in(1'b0, I_SW, 1'b0, 1'b0); cycle();
        set_in(1'b1, I_NOP, 1'b0, 1'b0);
        #2 RES = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs_cnt(i, 1) !== m_cnt[i][1] || obs_cnt(i, 3) !== m_cnt[i][3] || obs_state(i) !== m_state[i] ||
                obs_err(i) !== m_err[i] || obs_ecnt(i) !== m_ecnt[i]) begin
                bad++;
                $display("FAIL async_reset[%0d] cnt1=%0d cnt3=%0d state=%0d err=%0d ecnt=%0d want all 0",
                         i, obs_cnt(i, 1), obs_cnt(i, 3), obs_state(i), obs_err(i), obs_ecnt(i));
            end
        end
        @(posedge CLK);
        #1;
        RES = 1'b1;
        repeat (5) cycle();
        set_in(1'b0, I_NOP, 1'b0, 1'b0); repeat (4) cycle();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs_err(i) !== 0 || obs_state(i) !== 1 || obs_cnt(i, 1) !== m_cnt[i][1]) begin
                bad++;
                $display("FAIL reset_discard[%0d] err=%0d state=%0d cnt1=%0d want 0/1/%0d",
                         i, obs_err(i), obs_state(i), obs_cnt(i, 1), m_cnt[i][1]);
            end
        end
    endtask

    initial begin
        RES = 1'b1; CLR = 1'b0; IDLE = 1'b0;
        set_in(1'b1, I_NOP, 1'b0, 1'b0);
        model_reset(0);
        model_reset(1);
        test_reset();
        test_warmup();
        test_store_ok();
        test_clr_mid_store();
        test_wr_miss();
        test_illegal_rdwr();
        test_saturate();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
